sm83_bus_dma: RTL and testbench
===============================

// Module: sm83_bus_dma
// PURPOSE
//  Sits directly downstream of sm83_core's memory ports and owns OAM DMA.
//  - Splits CPU traffic: 0000-FEFF goes to the main bus (mem_*), FF00-FFFF to the high bus (hi_*).
//  - Implements the FF46 OAM DMA register: copies 160 bytes from {src,8'h00} into OAM, one byte/clk.
//  - Locks the CPU off the main bus while a copy runs.
// PARAMETERS
//  DMA_REG_ADDR  16'hFF46  CPU address of DMA source register
//  OAM_LEN       160       bytes per transfer
//  OPEN_BUS      8'hFF     CPU read data returned while main bus is locked
// PORTS
//  clk          in   1   clock; every clk is one M-cycle
//  rst          in   1   synchronous reset, active-high
//  cpu_r_addr   in   16  CPU read address (addr_t)
//  cpu_r_data   out  8   CPU read data (data_t), combinational
//  cpu_w_addr   in   16  CPU write address
//  cpu_w_data   in   8   CPU write data
//  cpu_w_wen    in   1   CPU write enable
//  mem_r_addr   out  16  main bus read address, async-read memory
//  mem_r_data   in   8   main bus read data
//  mem_w_addr   out  16  main bus write address
//  mem_w_data   out  8   main bus write data
//  mem_w_wen    out  1   main bus write enable
//  hi_r_addr    out  8   high bus read offset (addr[7:0])
//  hi_r_data    in   8   high bus read data
//  hi_w_addr    out  8   high bus write offset
//  hi_w_data    out  8   high bus write data
//  hi_w_wen     out  1   high bus write enable
//  oam_w_addr   out  8   OAM write index, 0..159
//  oam_w_data   out  8   OAM write data
//  oam_w_wen    out  1   OAM write enable
//  dma_busy     out  1   high in DMA_START or DMA_XFER
// BEHAVIOUR
//  - Reset values: state DMA_IDLE, src_q 8'hFF, idx 0, lock 0, every *_wen 0, dma_busy 0.
//  - High bus: FF00-FFFF always passes through, combinationally, except FF46.
//    - FF46 is never forwarded to hi_*.
//    - A CPU read of FF46 returns src_q.
//  - CPU write to FF46 in cycle N:
//    - src_q <= cpu_w_data; state <= DMA_START for cycle N+1.
//    - N+2..N+161: DMA_XFER, one byte per cycle.
//    - DMA_IDLE again at N+162.
//  - DMA_START: one cycle, no byte moved. lock keeps its current value, so a restart stays locked.
//  - DMA_XFER, cycle with index idx:
//    - mem_r_addr = {src_eff, idx}.
//    - oam_w_wen = 1, oam_w_addr = idx, oam_w_data = mem_r_data.
//    - idx++; after idx==OAM_LEN-1, state <= DMA_IDLE, idx <= 0, lock <= 0.
//    - lock <= 1 on entering DMA_XFER.
//  - src_eff = src_q - 8'h20 when src_q >= 8'hE0 (echo mirror), else src_q.
//  - While lock=1, CPU access to 0000-FEFF:
//    - Reads return OPEN_BUS.
//    - Writes are dropped: mem_w_wen = 0.
//    - mem_r_addr is owned by DMA.
//  - While lock=0, the CPU owns mem_*; mem_w_wen = cpu_w_wen & (cpu_w_addr < 16'hFF00).
//  - Restart: an FF46 write during DMA_START or DMA_XFER reloads src_q, idx <= 0, state <= DMA_START.
//    - The byte in flight that cycle still completes.
//  - Simultaneous FF46 write and final byte: the restart wins, so state goes to DMA_START, not DMA_IDLE.
//  - rst mid-transfer: back to reset values next edge; OAM keeps the bytes already written.
// STRUCTURE
//  - Add to sm83_pkg:
//    - dma_state_t {DMA_IDLE, DMA_START, DMA_XFER}
//    - constants HI_BASE = 8'hFF, ECHO_BASE = 8'hE0, ECHO_OFS = 8'h20
//  - Reuse addr_t and data_t.
//  - Flat module: a 3-state FSM, 8-bit idx counter, src_q, lock flag, and combinational routing muxes.
//  - No sub-module is warranted.
// TESTING
//  - Reset: rst=1 for 2 clks -> all *_wen 0, dma_busy 0; CPU read of FF46 returns 8'hFF.
//  - Pass-through, DMA idle:
//    - CPU writes 8'h5A to C000 -> mem_w_wen=1, mem_w_addr C000, mem_w_data 8'h5A.
//    - CPU writes 8'h12 to FF80 -> hi_w_wen=1, hi_w_addr 8'h80, hi_w_data 8'h12.
//  - Full copy: write 8'hC1 to FF46 at cycle N.
//    - oam_w_wen high for exactly 160 cycles, N+2..N+161.
//    - OAM[i] = mem[C100+i] for all i.
//    - dma_busy falls at N+162.
//  - Lockout: during the copy, CPU reads C000 -> 8'hFF; CPU writes to D000 do not change memory.
//    - CPU read and write of FF85 both succeed.
//  - Restart at idx 50: write 8'hD0 to FF46.
//    - One DMA_START cycle, with lock still high.
//    - Then 160 bytes from D000; completion 162 cycles after the second write.
//  - Echo source: src_q = 8'hE2 reads from E200.
//    - OAM[0..159] = mem[C200..C29F].

Source files
------------

// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared SM83 bus types, DMA states and address constants.
package sm83_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER
  } dma_state_t;

  localparam data_t HI_BASE   = 8'hFF;
  localparam data_t ECHO_BASE = 8'hE0;
  localparam data_t ECHO_OFS  = 8'h20;

endpackage

// File: rtl/sm83_bus_dma.sv
// rtl/sm83_bus_dma.sv - CPU bus splitter (main/high) with FF46 OAM DMA engine.
// DMA locks the CPU off the main bus while copying 160 bytes into OAM.
module sm83_bus_dma
  import sm83_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int          OAM_LEN      = 160,
  parameter logic [7:0]  OPEN_BUS     = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_r_addr,
  output logic [7:0]  cpu_r_data,
  input  logic [15:0] cpu_w_addr,
  input  logic [7:0]  cpu_w_data,
  input  logic        cpu_w_wen,
  output logic [15:0] mem_r_addr,
  input  logic [7:0]  mem_r_data,
  output logic [15:0] mem_w_addr,
  output logic [7:0]  mem_w_data,
  output logic        mem_w_wen,
  output logic [7:0]  hi_r_addr,
  input  logic [7:0]  hi_r_data,
  output logic [7:0]  hi_w_addr,
  output logic [7:0]  hi_w_data,
  output logic        hi_w_wen,
  output logic [7:0]  oam_w_addr,
  output logic [7:0]  oam_w_data,
  output logic        oam_w_wen,
  output logic        dma_busy
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  dma_state_t state_q, state_d;
  data_t      src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic       lock_q, lock_d;

  logic  cpu_r_hi, cpu_w_hi, dma_wr, dma_owns_bus;
  data_t src_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DMA_IDLE;
      src_q   <= 8'hFF;
      idx_q   <= 8'h00;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      lock_q  <= lock_d;
    end
  end

  assign cpu_r_hi = (cpu_r_addr[15:8] == HI_BASE);
  assign cpu_w_hi = (cpu_w_addr[15:8] == HI_BASE);
  assign dma_wr   = cpu_w_wen && (cpu_w_addr == DMA_REG_ADDR);
  // Echo RAM sources fold back onto work RAM.
  assign src_eff  = (src_q >= ECHO_BASE) ? (src_q - ECHO_OFS) : src_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    lock_d  = lock_q;
    unique case (state_q)
      DMA_START: begin
        state_d = DMA_XFER;
        idx_d   = 8'h00;
        lock_d  = 1'b1;
      end
      DMA_XFER: begin
        if (idx_q == LAST_IDX) begin
          state_d = DMA_IDLE;
          idx_d   = 8'h00;
          lock_d  = 1'b0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      default: ;
    endcase
    // A register write restarts the copy and outranks completion; lock is held as-is.
    if (dma_wr) begin
      src_d   = cpu_w_data;
      idx_d   = 8'h00;
      state_d = DMA_START;
      lock_d  = lock_q;
    end
  end

  assign dma_owns_bus = lock_q || (state_q == DMA_XFER);
  assign dma_busy     = (state_q != DMA_IDLE);

  assign mem_r_addr = dma_owns_bus ? {src_eff, idx_q} : cpu_r_addr;
  assign mem_w_addr = cpu_w_addr;
  assign mem_w_data = cpu_w_data;
  assign mem_w_wen  = !dma_owns_bus && cpu_w_wen && !cpu_w_hi;

  assign hi_r_addr = cpu_r_addr[7:0];
  assign hi_w_addr = cpu_w_addr[7:0];
  assign hi_w_data = cpu_w_data;
  assign hi_w_wen  = cpu_w_wen && cpu_w_hi && !dma_wr;

  assign oam_w_addr = idx_q;
  assign oam_w_data = mem_r_data;
  assign oam_w_wen  = (state_q == DMA_XFER);

  always_comb begin
    cpu_r_data = mem_r_data;
    if (cpu_r_addr == DMA_REG_ADDR) begin
      cpu_r_data = src_q;
    end else if (cpu_r_hi) begin
      cpu_r_data = hi_r_data;
    end else if (dma_owns_bus) begin
      cpu_r_data = OPEN_BUS;
    end
  end

endmodule

// File: tb/tb_sm83_bus_dma.sv
// tb/tb_sm83_bus_dma.sv - directed bench with a cycle-level reference model of sm83_bus_dma.
module tb_sm83_bus_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_r_addr;
  logic [7:0]  cpu_r_data;
  logic [15:0] cpu_w_addr;
  logic [7:0]  cpu_w_data;
  logic        cpu_w_wen;
  logic [15:0] mem_r_addr;
  logic [7:0]  mem_r_data;
  logic [15:0] mem_w_addr;
  logic [7:0]  mem_w_data;
  logic        mem_w_wen;
  logic [7:0]  hi_r_addr;
  logic [7:0]  hi_r_data;
  logic [7:0]  hi_w_addr;
  logic [7:0]  hi_w_data;
  logic        hi_w_wen;
  logic [7:0]  oam_w_addr;
  logic [7:0]  oam_w_data;
  logic        oam_w_wen;
  logic        dma_busy;

  sm83_bus_dma dut (
    .clk(clk), .rst(rst),
    .cpu_r_addr(cpu_r_addr), .cpu_r_data(cpu_r_data),
    .cpu_w_addr(cpu_w_addr), .cpu_w_data(cpu_w_data), .cpu_w_wen(cpu_w_wen),
    .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_w_wen(mem_w_wen),
    .hi_r_addr(hi_r_addr), .hi_r_data(hi_r_data),
    .hi_w_addr(hi_w_addr), .hi_w_data(hi_w_data), .hi_w_wen(hi_w_wen),
    .oam_w_addr(oam_w_addr), .oam_w_data(oam_w_data), .oam_w_wen(oam_w_wen),
    .dma_busy(dma_busy)
  );

  always #5 clk = ~clk;

  // Memories attached to the DUT.
  logic [7:0] mem    [0:65535];
  logic [7:0] hi_mem [0:255];
  logic [7:0] oam    [0:159];
  int         oam_cnt = 0;

  assign mem_r_data = mem[mem_r_addr];
  assign hi_r_data  = hi_mem[hi_r_addr];

  always @(posedge clk) begin
    if (mem_w_wen) mem[mem_w_addr] <= mem_w_data;
    if (hi_w_wen) hi_mem[hi_w_addr] <= hi_w_data;
    if (oam_w_wen && oam_w_addr < 8'd160) oam[oam_w_addr] <= oam_w_data;
    if (oam_w_wen) oam_cnt <= oam_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: timing derived from cycles elapsed since the last FF46 write.
  logic [7:0] ref_mem [0:65535];
  logic [7:0] hi_ref  [0:255];
  int         cyc = 0;
  int         last_wr = -1000;
  logic [7:0] m_src = 8'hFF;
  logic       m_prev_lock = 1'b0;

  always @(negedge clk) begin
    int k;
    logic st, xf, lk, mw, hw;
    logic [7:0] eff, idx, er;
    logic [15:0] da;
    if (rst) begin
      last_wr     = -1000;
      m_src       = 8'hFF;
      m_prev_lock = 1'b0;
    end else begin
      k   = cyc - last_wr;
      st  = (k == 1);
      xf  = (k >= 2) && (k <= 161);
      lk  = xf || (st && m_prev_lock);
      eff = (m_src >= 8'hE0) ? m_src - 8'h20 : m_src;
      idx = 8'(k - 2);
      da  = {eff, idx};
      chk("m_busy", dma_busy, st || xf);
      chk("m_oam_wen", oam_w_wen, xf);
      if (xf) begin
        chk("m_oam_addr", oam_w_addr, idx);
        chk("m_oam_data", oam_w_data, ref_mem[da]);
        chk("m_mem_r_addr_dma", mem_r_addr, da);
      end else if (!lk) begin
        chk("m_mem_r_addr_cpu", mem_r_addr, cpu_r_addr);
      end
      mw = !lk && cpu_w_wen && (cpu_w_addr < 16'hFF00);
      chk("m_mem_wen", mem_w_wen, mw);
      if (mw) begin
        chk("m_mem_w_addr", mem_w_addr, cpu_w_addr);
        chk("m_mem_w_data", mem_w_data, cpu_w_data);
      end
      hw = cpu_w_wen && (cpu_w_addr[15:8] == 8'hFF) && (cpu_w_addr != 16'hFF46);
      chk("m_hi_wen", hi_w_wen, hw);
      if (hw) begin
        chk("m_hi_w_addr", hi_w_addr, cpu_w_addr[7:0]);
        chk("m_hi_w_data", hi_w_data, cpu_w_data);
      end
      if (cpu_r_addr == 16'hFF46) er = m_src;
      else if (cpu_r_addr[15:8] == 8'hFF) er = hi_ref[cpu_r_addr[7:0]];
      else if (lk) er = 8'hFF;
      else er = ref_mem[cpu_r_addr];
      chk("m_cpu_r_data", cpu_r_data, er);
      if (cpu_w_wen && cpu_w_addr == 16'hFF46) begin
        m_src   = cpu_w_data;
        last_wr = cyc;
      end
      if (mw) ref_mem[cpu_w_addr] = cpu_w_data;
      if (hw) hi_ref[cpu_w_addr[7:0]] = cpu_w_data;
      m_prev_lock = lk;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ff46_write(input logic [7:0] v);
    cpu_w_addr = 16'hFF46;
    cpu_w_data = v;
    cpu_w_wen  = 1'b1;
    tick();
    cpu_w_wen  = 1'b0;
  endtask

  task automatic wait_idle(input int start, output int cnt);
    cnt = start;
    while (dma_busy && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    int cnt, c0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = pat(16'(i));
      ref_mem[i] = pat(16'(i));
    end
    for (int i = 0; i < 256; i++) begin
      hi_mem[i] = ~8'(i);
      hi_ref[i] = ~8'(i);
    end
    for (int i = 0; i < 160; i++) oam[i] = 8'h00;
    rst = 1'b1;
    cpu_r_addr = 16'hFF46;
    cpu_w_addr = 16'h0000;
    cpu_w_data = 8'h00;
    cpu_w_wen  = 1'b0;
    tick();
    tick();
    chk("rst_mem_wen", mem_w_wen, 1'b0);
    chk("rst_hi_wen", hi_w_wen, 1'b0);
    chk("rst_oam_wen", oam_w_wen, 1'b0);
    chk("rst_busy", dma_busy, 1'b0);
    chk("rst_ff46", cpu_r_data, 8'hFF);
    rst = 1'b0;
    tick();

    cpu_w_addr = 16'hC000; cpu_w_data = 8'h5A; cpu_w_wen = 1'b1;
    #1;
    chk("pt_mem_wen", mem_w_wen, 1'b1);
    chk("pt_mem_addr", mem_w_addr, 16'hC000);
    chk("pt_mem_data", mem_w_data, 8'h5A);
    tick();
    cpu_w_addr = 16'hFF80; cpu_w_data = 8'h12;
    #1;
    chk("pt_hi_wen", hi_w_wen, 1'b1);
    chk("pt_hi_addr", hi_w_addr, 8'h80);
    chk("pt_hi_data", hi_w_data, 8'h12);
    tick();
    cpu_w_wen = 1'b0;
    chk("pt_mem_c000", mem[16'hC000], 8'h5A);
    chk("pt_hi_80", hi_mem[8'h80], 8'h12);

    // Full copy from C100 with lockout probes.
    c0 = oam_cnt;
    ff46_write(8'hC1);
    tick();
    cpu_r_addr = 16'hC000;
    cpu_w_addr = 16'hD000; cpu_w_data = 8'h77; cpu_w_wen = 1'b1;
    #1;
    chk("lock_rd_c000", cpu_r_data, 8'hFF);
    chk("lock_mem_wen", mem_w_wen, 1'b0);
    tick();
    cpu_w_addr = 16'hFF85; cpu_w_data = 8'h3C;
    cpu_r_addr = 16'hFF85;
    tick();
    cpu_w_wen = 1'b0;
    chk("lock_hi_rd", cpu_r_data, 8'h3C);
    cpu_r_addr = 16'h0000;
    wait_idle(4, cnt);
    chk("full_len", cnt, 162);
    chk("full_oam_cnt", oam_cnt - c0, 160);
    chk("lock_d000_kept", mem[16'hD000], 8'hD0);
    chk("full_oam0", oam[0], 8'hC1);
    chk("full_oam159", oam[159], 8'h5E);
    for (int i = 0; i < 160; i++) chk("full_oam_i", oam[i], pat(16'hC100 + 16'(i)));

    // Restart at idx 50.
    c0 = oam_cnt;
    ff46_write(8'hC3);
    repeat (51) tick();
    chk("rs_idx50", oam_w_addr, 8'd50);
    cpu_r_addr = 16'hC000;
    ff46_write(8'hD0);
    #1;
    chk("rs_start_busy", dma_busy, 1'b1);
    chk("rs_start_oam", oam_w_wen, 1'b0);
    chk("rs_start_lock", cpu_r_data, 8'hFF);
    wait_idle(1, cnt);
    chk("rs_len", cnt, 162);
    chk("rs_oam_cnt", oam_cnt - c0, 211);
    chk("rs_oam0", oam[0], 8'hD0);
    chk("rs_oam50", oam[50], 8'hE2);
    chk("rs_oam159", oam[159], 8'h4F);

    // Echo source E2 mirrors C200.
    ff46_write(8'hE2);
    wait_idle(1, cnt);
    chk("echo_len", cnt, 162);
    cpu_r_addr = 16'hFF46;
    #1;
    chk("echo_ff46", cpu_r_data, 8'hE2);
    chk("echo_oam0", oam[0], 8'hC2);
    chk("echo_oam159", oam[159], 8'h5D);
    for (int i = 0; i < 160; i++) chk("echo_oam_i", oam[i], pat(16'hC200 + 16'(i)));

    // Reset mid-transfer keeps already-written OAM bytes.
    ff46_write(8'hC1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_busy", dma_busy, 1'b0);
    chk("mrst_oam_wen", oam_w_wen, 1'b0);
    chk("mrst_ff46", cpu_r_data, 8'hFF);
    chk("mrst_oam5", oam[5], 8'hC4);
    chk("mrst_oam100", oam[100], pat(16'hC264));
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
